cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for MEM_ACK before a request is aborted.
REQ-002 Parameter CNT_W, default 16: width of the hit and miss counters.
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 CPU_VALID  in  1  CPU request strobe.
REQ-006 CPU_WE  in  1  1 = write, 0 = read.
REQ-007 CPU_ADDR, CPU_WDATA  in  32 each  request address and write data.
REQ-008 CPU_READY  out  1  controller can accept a request; high only in IDLE.
REQ-009 CPU_RVALID  out  1  one-cycle response strobe.
REQ-010 CPU_RDATA  out  32  response data.
REQ-011 CPU_ERR  out  1  response is a timeout abort; qualified by CPU_RVALID.
REQ-012 LK_ADDR, LK_DIN  out  32 each  lookup cache address and fill data.
REQ-013 LK_WE  out  1  lookup cache shift-in strobe.
REQ-014 LK_DOUT  in  32  lookup cache data, combinational from LK_ADDR.
REQ-015 LK_FOUND  in  1  lookup cache hit flag, combinational from LK_ADDR.
REQ-016 MEM_REQ, MEM_WE  out  1 each  memory request and its direction.
REQ-017 MEM_ADDR, MEM_WDATA  out  32 each  memory address and write data.
REQ-018 MEM_ACK  in  1  one-cycle memory completion strobe.
REQ-019 MEM_RDATA  in  32  read data; valid when MEM_ACK is high.
REQ-020 HIT_CNT, MISS_CNT  out  CNT_W each  statistics counters.

Function
REQ-021 States SHALL be IDLE, LOOKUP, MEM_RD, MEM_WR, FILL and RESP.
REQ-022 IDLE: on CPU_VALID, latch CPU_ADDR, CPU_WDATA and CPU_WE, then go to LOOKUP; CPU_VALID outside IDLE is ignored.
REQ-023 LK_ADDR SHALL equal the latched address in every state except IDLE.
REQ-024 LOOKUP, read with LK_FOUND=1: capture LK_DOUT, increment HIT_CNT, go to RESP.
REQ-025 LOOKUP, read with LK_FOUND=0: increment MISS_CNT, go to MEM_RD.
REQ-026 LOOKUP, write: go to MEM_WR (write-through, write-allocate); hit and miss counters are unchanged.
REQ-027 MEM_RD/MEM_WR: hold MEM_REQ=1 with stable MEM_ADDR, MEM_WE and MEM_WDATA until MEM_ACK.
- On MEM_ACK, go to FILL with fill data = MEM_RDATA (read) or the latched write data (write).
REQ-028 FILL: assert LK_WE for exactly one cycle with LK_DIN = fill data, then go to RESP.
- The newest entry shadows stale copies, so no invalidate is required.
REQ-029 RESP: assert CPU_RVALID for one cycle, then go to IDLE.
- Read: CPU_RDATA = captured data.
- Write: CPU_RDATA = written data.
REQ-030 Latency from the accepting edge to CPU_RVALID high SHALL be:
- Read hit: 2 cycles.
- Miss or write: 4 + k cycles, where k = number of cycles MEM_REQ is high before MEM_ACK (k=0 if ACK arrives in the first request cycle).
REQ-031 A wait counter SHALL clear on entry to MEM_RD/MEM_WR and increment each waiting cycle.
- On reaching TIMEOUT without ACK: drop MEM_REQ, skip FILL, and enter RESP with CPU_ERR=1 and CPU_RDATA=0.
REQ-032 MEM_ACK in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-033 MEM_ACK outside MEM_RD/MEM_WR SHALL be ignored.
REQ-034 HIT_CNT and MISS_CNT SHALL saturate at all-ones and never wrap.
REQ-035 LK_WE SHALL never be high outside FILL.
- MEM_REQ SHALL never be high outside MEM_RD/MEM_WR.

Reset
REQ-036 RST SHALL force IDLE and clear all of the following on the next edge, including mid-transaction:
- Outputs: CPU_RVALID, CPU_ERR, CPU_RDATA, LK_WE, MEM_REQ, MEM_WE, HIT_CNT, MISS_CNT.
- Internal state: the wait counter and the request latches.
REQ-037 CPU_READY SHALL be 1 in the first cycle after reset deasserts.
- A pending memory ACK arriving after reset is dropped.

Structure
REQ-038 A shared package SHALL hold the state encoding constants and the TIMEOUT/CNT_W defaults.
REQ-039 One sub-module, sat_counter (parameter width; inc and clear inputs), SHALL implement both statistics counters.
REQ-040 The existing lookup cache SHALL be instantiated by the parent, not inside this block.

Verification
REQ-041 Read 0x100, cache holds {0x100, 0xDEADBEEF} -> RVALID 2 cycles after accept, RDATA=0xDEADBEEF, HIT_CNT=1, MEM_REQ never high.
REQ-042 Read miss 0x200, memory ACKs with 0x12345678 after 3 wait cycles -> one LK_WE pulse with LK_DIN=0x12345678, RVALID at cycle 7, MISS_CNT=1; repeat read -> hit.
REQ-043 Write 0x300=0xA5A5A5A5 with ACK at k=0 -> MEM_WE=1, MEM_WDATA=0xA5A5A5A5, LK_WE pulse, RVALID at cycle 4; subsequent read of 0x300 hits with 0xA5A5A5A5.
REQ-044 No ACK, TIMEOUT=8 -> MEM_REQ high 8 cycles, RVALID with ERR=1 and RDATA=0, no LK_WE; second test with ACK on the timeout cycle -> ERR=0.
REQ-045 RST asserted while in MEM_RD -> next cycle MEM_REQ=0, CPU_READY=1, counters 0; late ACK produces no RVALID.
REQ-046 CNT_W=2, five read hits -> HIT_CNT stays 3 after the third hit.

Source files
------------

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and defaults for the cache fill controller.
//   state_t : controller state encoding
//   req_t   : latched CPU request payload
package cache_fill_ctrl_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_FILL   = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Data written into the lookup cache after a memory completion.
    function automatic logic [DATA_W-1:0] fill_select(
        input logic              we,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rdata
    );
        return we ? wdata : rdata;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit/miss statistics.
//   CLK   : clock
//   clear : synchronous clear (wins over inc)
//   inc   : increment request, ignored once all-ones
//   count : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache fill controller: looks up the external shift-in cache, goes to memory
// on read misses and on all writes (write-through, write-allocate), fills the
// cache and returns a one-cycle response. Memory waits are bounded by TIMEOUT.
//   CPU_*      : request/response port (CPU_READY high only in IDLE)
//   LK_*       : external lookup cache (LK_DOUT/LK_FOUND combinational)
//   MEM_*      : memory request port, MEM_ACK one-cycle completion
//   HIT_CNT/MISS_CNT : saturating statistics
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_VALID,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_READY,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ERR,
    output logic [ADDR_W-1:0] LK_ADDR,
    output logic [DATA_W-1:0] LK_DIN,
    output logic              LK_WE,
    input  logic [DATA_W-1:0] LK_DOUT,
    input  logic              LK_FOUND,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  MISS_CNT
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_q;
    req_t                req_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                hit_inc_c;
    logic                miss_inc_c;

    // Address and write data are driven straight from the request latch, so
    // they stay stable for the whole memory handshake.
    assign LK_ADDR   = req_q.addr;
    assign MEM_ADDR  = req_q.addr;
    assign MEM_WDATA = req_q.wdata;
    assign LK_DIN    = data_q;

    assign hit_inc_c  = (state_q == ST_LOOKUP) && !req_q.we &&  LK_FOUND;
    assign miss_inc_c = (state_q == ST_LOOKUP) && !req_q.we && !LK_FOUND;

    // Controller FSM; CPU_RVALID lags the RESP state by one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
            CPU_READY  <= 1'b1;
            CPU_RVALID <= 1'b0;
            CPU_RDATA  <= '0;
            CPU_ERR    <= 1'b0;
            LK_WE      <= 1'b0;
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
        end else begin
            CPU_RVALID <= 1'b0;
            CPU_ERR    <= 1'b0;
            LK_WE      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (CPU_VALID) begin
                        req_q     <= '{we: CPU_WE, addr: CPU_ADDR, wdata: CPU_WDATA};
                        err_q     <= 1'b0;
                        CPU_READY <= 1'b0;
                        state_q   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (req_q.we) begin
                        wait_q  <= '0;
                        MEM_REQ <= 1'b1;
                        MEM_WE  <= 1'b1;
                        state_q <= ST_MEM_WR;
                    end else if (LK_FOUND) begin
                        data_q  <= LK_DOUT;
                        state_q <= ST_RESP;
                    end else begin
                        wait_q  <= '0;
                        MEM_REQ <= 1'b1;
                        MEM_WE  <= 1'b0;
                        state_q <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    // ACK is checked first so it wins over a coincident timeout.
                    if (MEM_ACK) begin
                        data_q  <= fill_select(req_q.we, req_q.wdata, MEM_RDATA);
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        LK_WE   <= 1'b1;
                        state_q <= ST_FILL;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        state_q <= ST_RESP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_FILL: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    CPU_RVALID <= 1'b1;
                    CPU_RDATA  <= data_q;
                    CPU_ERR    <= err_q;
                    CPU_READY  <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    MEM_REQ   <= 1'b0;
                    MEM_WE    <= 1'b0;
                    CPU_READY <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .CLK   (CLK),
        .clear (RST),
        .inc   (hit_inc_c),
        .count (HIT_CNT)
    );

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .CLK   (CLK),
        .clear (RST),
        .inc   (miss_inc_c),
        .count (MISS_CNT)
    );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a shift-in lookup cache stand-in,
// a transaction-level timing model and hand-computed literal expectations.
module tb_cache_fill_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int DEPTH   = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic              CPU_VALID;
    logic              CPU_WE;
    logic [31:0]       CPU_ADDR;
    logic [31:0]       CPU_WDATA;
    logic              CPU_READY;
    logic              CPU_RVALID;
    logic [31:0]       CPU_RDATA;
    logic              CPU_ERR;
    logic [31:0]       LK_ADDR;
    logic [31:0]       LK_DIN;
    logic              LK_WE;
    logic [31:0]       LK_DOUT;
    logic              LK_FOUND;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [31:0]       MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic              MEM_ACK;
    logic [31:0]       MEM_RDATA;
    logic [CNT_W-1:0]  HIT_CNT;
    logic [CNT_W-1:0]  MISS_CNT;

    int n_chk  = 0;
    int n_fail = 0;
    int hit_m  = 0;
    int miss_m = 0;
    logic [31:0] mc [logic [31:0]];

    always #5 CLK = ~CLK;

    cache_fill_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CPU_VALID  (CPU_VALID),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_READY  (CPU_READY),
        .CPU_RVALID (CPU_RVALID),
        .CPU_RDATA  (CPU_RDATA),
        .CPU_ERR    (CPU_ERR),
        .LK_ADDR    (LK_ADDR),
        .LK_DIN     (LK_DIN),
        .LK_WE      (LK_WE),
        .LK_DOUT    (LK_DOUT),
        .LK_FOUND   (LK_FOUND),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_ACK    (MEM_ACK),
        .MEM_RDATA  (MEM_RDATA),
        .HIT_CNT    (HIT_CNT),
        .MISS_CNT   (MISS_CNT)
    );

    // Shift-in lookup cache stand-in; slot 0 is newest and wins on lookup.
    logic        preload;
    logic [31:0] c_addr [DEPTH];
    logic [31:0] c_data [DEPTH];
    logic        c_vld  [DEPTH];

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) begin
                c_vld[i]  <= 1'b0;
                c_addr[i] <= 32'h0;
                c_data[i] <= 32'h0;
            end
            c_vld[0]  <= 1'b1;
            c_addr[0] <= 32'h0000_0100;
            c_data[0] <= 32'hDEAD_BEEF;
        end else if (LK_WE) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                c_vld[i]  <= c_vld[i-1];
                c_addr[i] <= c_addr[i-1];
                c_data[i] <= c_data[i-1];
            end
            c_vld[0]  <= 1'b1;
            c_addr[0] <= LK_ADDR;
            c_data[0] <= LK_DIN;
        end
    end

    always_comb begin
        LK_FOUND = 1'b0;
        LK_DOUT  = 32'h0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (c_vld[i] && (c_addr[i] == LK_ADDR)) begin
                LK_FOUND = 1'b1;
                LK_DOUT  = c_data[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // One CPU transaction. ack_k < 0 means memory never answers. Every cycle
    // from acceptance to the response strobe is checked against the timing
    // expected from the request kind; lit_* pin the response value by hand.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_k, input logic [31:0] mem_data,
                           input logic [31:0] lit_rdata, input logic lit_err);
        bit          hit, fill, err, in_req;
        int          lat, req_last, hit0, miss0, hit1, miss1;
        logic [31:0] exp_data;
        hit      = !we && mc.exists(addr);
        fill     = 1'b0;
        err      = 1'b0;
        req_last = 0;
        if (hit) begin
            lat      = 2;
            exp_data = mc[addr];
        end else if (ack_k >= 0) begin
            lat      = 4 + ack_k;
            req_last = 1 + ack_k;
            fill     = 1'b1;
            exp_data = we ? wdata : mem_data;
        end else begin
            lat      = TIMEOUT + 2;
            req_last = TIMEOUT;
            err      = 1'b1;
            exp_data = 32'h0;
        end
        hit0  = hit_m;
        miss0 = miss_m;
        hit1  = hit ? sat_inc(hit0) : hit0;
        miss1 = (!we && !hit) ? sat_inc(miss0) : miss0;

        chk("ready_before_accept", 32'(CPU_READY), 32'd1);
        CPU_VALID = 1'b1;
        CPU_WE    = we;
        CPU_ADDR  = addr;
        CPU_WDATA = wdata;
        MEM_ACK   = 1'b0;

        for (int n = 0; n <= lat; n++) begin
            @(negedge CLK);
            in_req = !hit && (n >= 1) && (n <= req_last);
            chk("rvalid", 32'(CPU_RVALID), 32'(n == lat));
            if (n == lat) begin
                chk("rdata_model", CPU_RDATA, exp_data);
                chk("rdata_literal", CPU_RDATA, lit_rdata);
                chk("err_model", 32'(CPU_ERR), 32'(err));
                chk("err_literal", 32'(CPU_ERR), 32'(lit_err));
            end
            chk("ready", 32'(CPU_READY), 32'(n >= lat));
            chk("mem_req", 32'(MEM_REQ), 32'(in_req));
            if (in_req) begin
                chk("mem_we", 32'(MEM_WE), 32'(we));
                chk("mem_addr", MEM_ADDR, addr);
                if (we) chk("mem_wdata", MEM_WDATA, wdata);
            end
            chk("lk_we", 32'(LK_WE), 32'(fill && (n == req_last + 1)));
            if (fill && (n == req_last + 1)) chk("lk_din", LK_DIN, exp_data);
            if (n < lat) chk("lk_addr", LK_ADDR, addr);
            chk("hit_cnt", 32'(HIT_CNT), 32'((n == 0) ? hit0 : hit1));
            chk("miss_cnt", 32'(MISS_CNT), 32'((n == 0) ? miss0 : miss1));

            // Busy-time CPU requests must be ignored; stray ACKs in LOOKUP
            // and RESP must be ignored too.
            if (n <= lat - 1) begin
                CPU_VALID = 1'b1;
                CPU_WE    = ~we;
                CPU_ADDR  = addr ^ 32'hFFFF_0000;
                CPU_WDATA = ~wdata;
            end else begin
                CPU_VALID = 1'b0;
            end
            if (ack_k >= 0 && !hit && (n == ack_k + 1)) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = mem_data;
            end else if (n < lat && ((n == 0) || (n == lat - 1))) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = 32'hBAD0_0000 | 32'(n);
            end else begin
                MEM_ACK   = 1'b0;
                MEM_RDATA = 32'h5A5A_5A5A;
            end
        end
        hit_m  = hit1;
        miss_m = miss1;
        if (fill) mc[addr] = exp_data;
    endtask

    initial begin
        RST       = 1'b1;
        preload   = 1'b1;
        CPU_VALID = 1'b0;
        CPU_WE    = 1'b0;
        CPU_ADDR  = 32'h0;
        CPU_WDATA = 32'h0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'h0;
        mc[32'h0000_0100] = 32'hDEAD_BEEF;

        repeat (2) @(negedge CLK);
        preload = 1'b0;
        chk("rst_ready", 32'(CPU_READY), 32'd1);
        chk("rst_rvalid", 32'(CPU_RVALID), 32'd0);
        chk("rst_err", 32'(CPU_ERR), 32'd0);
        chk("rst_rdata", CPU_RDATA, 32'h0);
        chk("rst_lk_we", 32'(LK_WE), 32'd0);
        chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
        chk("rst_mem_we", 32'(MEM_WE), 32'd0);
        chk("rst_hit", 32'(HIT_CNT), 32'd0);
        chk("rst_miss", 32'(MISS_CNT), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 32'(CPU_READY), 32'd1);

        run_txn(1'b0, 32'h100, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("hit_after_first_hit", 32'(HIT_CNT), 32'd1);
        run_txn(1'b0, 32'h200, 32'h0, 3, 32'h1234_5678, 32'h1234_5678, 1'b0);
        chk("miss_after_first_miss", 32'(MISS_CNT), 32'd1);
        run_txn(1'b0, 32'h200, 32'h0, -1, 32'h0, 32'h1234_5678, 1'b0);
        run_txn(1'b1, 32'h300, 32'hA5A5_A5A5, 0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b0);
        run_txn(1'b0, 32'h300, 32'h0, -1, 32'h0, 32'hA5A5_A5A5, 1'b0);
        chk("hit_after_third_hit", 32'(HIT_CNT), 32'd3);
        run_txn(1'b0, 32'h400, 32'h0, -1, 32'h0, 32'h0, 1'b1);
        run_txn(1'b0, 32'h400, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        run_txn(1'b0, 32'h100, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 32'h200, 32'h0, -1, 32'h0, 32'h1234_5678, 1'b0);
        chk("hit_saturated", 32'(HIT_CNT), 32'd3);
        run_txn(1'b0, 32'h500, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        chk("miss_saturated", 32'(MISS_CNT), 32'd3);
        run_txn(1'b1, 32'h100, 32'h1111_2222, 2, 32'h0, 32'h1111_2222, 1'b0);
        run_txn(1'b0, 32'h100, 32'h0, -1, 32'h0, 32'h1111_2222, 1'b0);

        // Reset in the middle of a memory read.
        chk("ready_before_rst_txn", 32'(CPU_READY), 32'd1);
        CPU_VALID = 1'b1;
        CPU_WE    = 1'b0;
        CPU_ADDR  = 32'h600;
        @(negedge CLK);
        CPU_VALID = 1'b0;
        @(negedge CLK);
        chk("mid_mem_req", 32'(MEM_REQ), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_mem_req", 32'(MEM_REQ), 32'd0);
        chk("midrst_ready", 32'(CPU_READY), 32'd1);
        chk("midrst_hit", 32'(HIT_CNT), 32'd0);
        chk("midrst_miss", 32'(MISS_CNT), 32'd0);
        chk("midrst_rvalid", 32'(CPU_RVALID), 32'd0);
        chk("midrst_rdata", CPU_RDATA, 32'h0);
        chk("midrst_lk_we", 32'(LK_WE), 32'd0);
        chk("midrst_mem_we", 32'(MEM_WE), 32'd0);
        RST       = 1'b0;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h7777_7777;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        chk("postrst_ready", 32'(CPU_READY), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("late_ack_rvalid", 32'(CPU_RVALID), 32'd0);
            chk("late_ack_mem_req", 32'(MEM_REQ), 32'd0);
            chk("late_ack_lk_we", 32'(LK_WE), 32'd0);
            @(negedge CLK);
        end
        hit_m  = 0;
        miss_m = 0;
        run_txn(1'b0, 32'h100, 32'h0, -1, 32'h0, 32'h1111_2222, 1'b0);
        chk("hit_after_rst", 32'(HIT_CNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
